pipeline_ctrl: RTL

Central stall/flush sequencer for the out-of-order pipeline; drives the stall/flush outputs of hazard_intf (dreg..creg) from structural-full signals, ROB redirects and CSR/mret serialization. Owns a small FSM for reset-init bubbles, post-redirect RAT recovery and ROB-drain serialization. Sits beside the pipeline registers; inputs come from issue, rob, fetch and rename.

---
 rtl/pipeline_ctrl_pkg.sv | 27 ++
 rtl/pipeline_ctrl.sv | 118 +++++++++++
 2 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared hazard-level types for the stall/flush sequencer.
//   ctrl_state_t         : sequencer FSM states
//   RECOVER_CYCLES_DEF   : default front-end hold after a redirect
//   STALL_* / FLUSH_*    : bit positions inside the packed stall/flush vectors
package pipeline_ctrl_pkg;

  typedef enum logic [2:0] {
    INIT,
    RUN,
    RECOVER,
    DRAIN_PRE,
    PASS,
    DRAIN_POST
  } ctrl_state_t;

  localparam int unsigned RECOVER_CYCLES_DEF = 2;

  // stall vector {F,D,R,I,S,E,C}, flush vector {D,R,I,S,E,C}
  localparam logic [6:0] STALL_NONE   = 7'b0000000;
  localparam logic [6:0] STALL_FRONT  = 7'b1110000;
  localparam logic [6:0] STALL_PC     = 7'b1000000;
  localparam logic [5:0] FLUSH_NONE   = 6'b000000;
  localparam logic [5:0] FLUSH_ALL    = 6'b111111;
  localparam logic [5:0] FLUSH_IREG   = 6'b001000;
  localparam logic [5:0] FLUSH_DREG   = 6'b100000;

endpackage

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the out-of-order pipeline.
// Inputs : clk, resetn (async, active-low), iq_full, rob_full, pd_fail,
//          imem_busy, redirect, serialize_req, rob_empty
// Outputs: stallF..stallC (hold pc / pipeline register),
//          flushD..flushC (load bubble), busy (state != RUN)
// All outputs are combinational from state and inputs; a flush on a stage
// always overrides a stall on the same stage.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned RECOVER_CYCLES = RECOVER_CYCLES_DEF,
  parameter int unsigned CNT_W          = $clog2(RECOVER_CYCLES + 1)
) (
  input  logic clk,
  input  logic resetn,
  input  logic iq_full,
  input  logic rob_full,
  input  logic pd_fail,
  input  logic imem_busy,
  input  logic redirect,
  input  logic serialize_req,
  input  logic rob_empty,
  output logic stallF,
  output logic stallD,
  output logic stallR,
  output logic stallI,
  output logic stallS,
  output logic stallE,
  output logic stallC,
  output logic flushD,
  output logic flushR,
  output logic flushI,
  output logic flushS,
  output logic flushE,
  output logic flushC,
  output logic busy
);

  ctrl_state_t state, stateNext;
  logic [CNT_W-1:0] cnt, cntNext;
  logic [6:0] stallRaw;
  logic [5:0] flushRaw;
  logic structStall;

  assign structStall = iq_full | rob_full | pd_fail;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= INIT;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stallRaw  = STALL_NONE;
    flushRaw  = FLUSH_NONE;

    if (state == INIT) begin
      stallRaw  = STALL_PC;
      flushRaw  = FLUSH_ALL;
      stateNext = RUN;
    end else if (redirect) begin
      // pc register must load the redirect target, so stallF stays low
      flushRaw  = FLUSH_ALL;
      stateNext = RECOVER;
      cntNext   = CNT_W'(RECOVER_CYCLES);
    end else begin
      unique case (state)
        RUN: begin
          // a serializing instruction is held at rename until the ROB drains
          if (structStall || serialize_req) begin
            stallRaw = STALL_FRONT;
            flushRaw = FLUSH_IREG;
          end else if (imem_busy) begin
            flushRaw = FLUSH_DREG;
          end
          if (serialize_req) stateNext = DRAIN_PRE;
        end
        RECOVER: begin
          stallRaw = STALL_PC;
          flushRaw = FLUSH_DREG;
          cntNext  = cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) stateNext = RUN;
        end
        DRAIN_PRE: begin
          stallRaw = STALL_FRONT;
          flushRaw = FLUSH_IREG;
          if (rob_empty) stateNext = PASS;
        end
        PASS: begin
          if (structStall) begin
            stallRaw = STALL_FRONT;
            flushRaw = FLUSH_IREG;
          end else begin
            stateNext = DRAIN_POST;
          end
        end
        DRAIN_POST: begin
          stallRaw = STALL_FRONT;
          flushRaw = FLUSH_IREG;
          if (rob_empty) stateNext = RUN;
        end
        default: stateNext = INIT;
      endcase
    end
  end

  assign stallF = stallRaw[6];
  assign {stallD, stallR, stallI, stallS, stallE, stallC} = stallRaw[5:0] & ~flushRaw;
  assign {flushD, flushR, flushI, flushS, flushE, flushC} = flushRaw;
  assign busy = (state != RUN);

endmodule
